// File: rtl/serial_word_deser_pkg.sv
// Shared definitions for the framed serial word deserialiser: state codes and default sizing.
package serial_word_deser_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_PAR  = 2'd2;

   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_MAX_WORDS = 33;
   localparam int unsigned WORD_CNT_W    = 6;

endpackage

// File: rtl/serial_word_deser_shift.sv
// Serial-in/parallel-out shift register, MSB first, with shift enable and synchronous clear.
module deser_shift
   import serial_word_deser_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_sin,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Clear together with enable loads the incoming bit as the first bit of a fresh word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_q <= '0;
      else if (i_clr)
         r_q <= {{(WIDTH-1){1'b0}}, i_en & i_sin};
      else if (i_en)
         r_q <= {r_q[WIDTH-2:0], i_sin};
   end

   assign o_q = r_q;

endmodule

// File: rtl/serial_word_deser.sv
// Framed serial-to-word deserialiser with per-word parity check and a per-frame word limit.
module serial_word_deser
   import serial_word_deser_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned MAX_WORDS  = DEF_MAX_WORDS,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_sin,
   input  logic             i_sin_en,
   input  logic             i_sof,
   output logic [WIDTH-1:0] o_data,
   output logic             o_data_valid,
   output logic             o_par_err,
   output logic             o_frame_err,
   output logic             o_busy,
   output logic             o_ovf
);

   localparam int unsigned BCW = $clog2(WIDTH + 1);

   logic [1:0]            r_state;
   logic [BCW-1:0]        r_bit_cnt;
   logic [WORD_CNT_W-1:0] r_word_cnt;
   logic [WIDTH-1:0]      r_data;
   logic                  r_dv;
   logic                  r_pe;
   logic                  r_fe;
   logic                  r_busy;
   logic                  r_ovf;

   logic [WIDTH-1:0]      w_word;
   logic                  w_start;
   logic                  w_shift;
   logic                  w_par_ok;

   // A qualified sof bit always begins a new word, whatever state we are in.
   assign w_start  = i_sin_en & i_sof;
   assign w_shift  = i_sin_en & ~i_sof & (r_state == ST_DATA);
   assign w_par_ok = ((^w_word) ^ i_sin) == PARITY_ODD;

   deser_shift #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_start | w_shift),
      .i_clr (w_start),
      .i_sin (i_sin),
      .o_q   (w_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_data     <= '0;
         r_dv       <= 1'b0;
         r_pe       <= 1'b0;
         r_fe       <= 1'b0;
         r_busy     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_dv <= 1'b0;
         r_pe <= 1'b0;
         r_fe <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (w_start) begin
               r_state    <= ST_DATA;
               r_bit_cnt  <= BCW'(1);
               r_word_cnt <= '0;
               r_ovf      <= 1'b0;
               r_busy     <= 1'b1;
            end
         end else if (!i_sin_en) begin
            // Bits never stall: a gap inside a word aborts, a gap on a word boundary ends the frame.
            if (r_state == ST_PAR || r_bit_cnt != '0)
               r_fe <= 1'b1;
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
         end else if (i_sof) begin
            if (r_bit_cnt != '0)
               r_fe <= 1'b1;
            r_state    <= ST_DATA;
            r_bit_cnt  <= BCW'(1);
            r_word_cnt <= '0;
            r_ovf      <= 1'b0;
         end else if (r_state == ST_DATA) begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
            if (r_bit_cnt == BCW'(WIDTH - 1))
               r_state <= ST_PAR;
         end else begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            if (!w_par_ok) begin
               r_pe <= 1'b1;
            end else if (r_word_cnt < WORD_CNT_W'(MAX_WORDS)) begin
               r_data     <= w_word;
               r_dv       <= 1'b1;
               r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
            end else begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign o_data       = r_data;
   assign o_data_valid = r_dv;
   assign o_par_err    = r_pe;
   assign o_frame_err  = r_fe;
   assign o_busy       = r_busy;
   assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_serial_word_deser.sv
// Randomised and directed bench for serial_word_deser against a queue-based frame model.
module tb_serial_word_deser;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned MAX_WORDS = 33;
   localparam bit          PODD      = 1'b0;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sin = 1'b0;
   logic             sin_en = 1'b0;
   logic             sof = 1'b0;
   logic [WIDTH-1:0] data;
   logic             data_valid;
   logic             par_err;
   logic             frame_err;
   logic             busy;
   logic             ovf;

   int n_total = 0;
   int n_bad   = 0;
   int dv_seen = 0;
   int pe_seen = 0;
   int fe_seen = 0;

   // reference model state
   bit               m_in_frame;
   int               m_q[$];
   int               m_words;
   logic [WIDTH-1:0] m_data;
   logic             m_dv, m_pe, m_fe, m_ovf;

   logic [WIDTH-1:0] t3_words[35];

   serial_word_deser #(
      .WIDTH      (WIDTH),
      .MAX_WORDS  (MAX_WORDS),
      .PARITY_ODD (PODD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_sin        (sin),
      .i_sin_en     (sin_en),
      .i_sof        (sof),
      .o_data       (data),
      .o_data_valid (data_valid),
      .o_par_err    (par_err),
      .o_frame_err  (frame_err),
      .o_busy       (busy),
      .o_ovf        (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in_frame = 1'b0;
      m_q.delete();
      m_words = 0;
      m_data  = '0;
      m_dv = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic model_step(input logic r, input logic b, input logic en, input logic s);
      int ones;
      logic [WIDTH-1:0] w;
      m_dv = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
      if (r) begin
         model_reset();
      end else if (!m_in_frame) begin
         if (en && s) begin
            m_in_frame = 1'b1;
            m_q = '{int'(b)};
            m_words = 0;
            m_ovf = 1'b0;
         end
      end else if (!en) begin
         if (m_q.size() != 0) m_fe = 1'b1;
         m_in_frame = 1'b0;
         m_q.delete();
      end else if (s) begin
         if (m_q.size() != 0) m_fe = 1'b1;
         m_q = '{int'(b)};
         m_words = 0;
         m_ovf = 1'b0;
      end else if (m_q.size() < WIDTH) begin
         m_q.push_back(int'(b));
      end else begin
         w = '0;
         ones = int'(b);
         foreach (m_q[i]) begin
            w = {w[WIDTH-2:0], m_q[i][0]};
            ones += m_q[i];
         end
         m_q.delete();
         if ((ones % 2) != int'(PODD)) begin
            m_pe = 1'b1;
         end else if (m_words < MAX_WORDS) begin
            m_data = w;
            m_dv = 1'b1;
            m_words++;
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check_val("data", 32'(data), 32'(m_data));
      check_val("data_valid", 32'(data_valid), 32'(m_dv));
      check_val("par_err", 32'(par_err), 32'(m_pe));
      check_val("frame_err", 32'(frame_err), 32'(m_fe));
      check_val("busy", 32'(busy), 32'(m_in_frame));
      check_val("ovf", 32'(ovf), 32'(m_ovf));
      if (data_valid === 1'b1) dv_seen++;
      if (par_err === 1'b1) pe_seen++;
      if (frame_err === 1'b1) fe_seen++;
   endtask

   // Inputs change only just after a falling edge; outputs are compared at the next falling edge.
   task automatic tick(input logic b, input logic en, input logic s);
      sin = b; sin_en = en; sof = s;
      @(posedge clk);
      model_step(rst, b, en, s);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'($urandom), 1'b0, 1'b0);
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input bit bad, input bit first);
      logic p;
      for (int i = WIDTH - 1; i >= 0; i--) tick(w[i], 1'b1, first && (i == WIDTH - 1));
      p = (^w) ^ PODD ^ bad;
      tick(p, 1'b1, 1'b0);
   endtask

   task automatic send_partial(input logic [WIDTH-1:0] w, input int k, input bit first);
      for (int i = 0; i < k; i++) tick(w[WIDTH-1-i], 1'b1, first && (i == 0));
   endtask

   initial begin
      int dv0, pe0, fe0;
      logic [WIDTH-1:0] w;
      bit first;
      int nw, r;

      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      compare_all();
      check_val("rst_data", 32'(data), 32'h0);
      rst = 1'b0;
      idle(2);

      // 1: single good word
      dv0 = dv_seen;
      send_word(8'hA5, 1'b0, 1'b1);
      check_val("t1_dv_cycle", 32'(data_valid), 32'h1);
      check_val("t1_data", 32'(data), 32'hA5);
      tick(1'b0, 1'b0, 1'b0);
      check_val("t1_busy", 32'(busy), 32'h0);
      check_val("t1_dv_count", 32'(dv_seen - dv0), 32'h1);

      // 2: wrong parity
      dv0 = dv_seen; pe0 = pe_seen;
      send_word(8'h3C, 1'b1, 1'b1);
      check_val("t2_pe_cycle", 32'(par_err), 32'h1);
      tick(1'b0, 1'b0, 1'b0);
      check_val("t2_pe_count", 32'(pe_seen - pe0), 32'h1);
      check_val("t2_no_dv", 32'(dv_seen - dv0), 32'h0);
      check_val("t2_data_kept", 32'(data), 32'hA5);

      // 3: 35 words in one frame
      dv0 = dv_seen;
      for (int i = 0; i < 35; i++) begin
         t3_words[i] = WIDTH'($urandom);
         send_word(t3_words[i], 1'b0, i == 0);
         if (i == 32) check_val("t3_no_ovf_at_33", 32'(ovf), 32'h0);
         if (i == 33) check_val("t3_ovf_at_34", 32'(ovf), 32'h1);
      end
      tick(1'b0, 1'b0, 1'b0);
      check_val("t3_dv_count", 32'(dv_seen - dv0), 32'd33);
      check_val("t3_ovf", 32'(ovf), 32'h1);
      check_val("t3_data", 32'(data), 32'(t3_words[32]));

      // 4: drop after 4 bits, then a normal frame
      dv0 = dv_seen; fe0 = fe_seen;
      send_partial(8'h96, 4, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      check_val("t4_fe", 32'(frame_err), 32'h1);
      check_val("t4_idle", 32'(busy), 32'h0);
      check_val("t4_no_dv", 32'(dv_seen - dv0), 32'h0);
      send_word(8'h5A, 1'b0, 1'b1);
      check_val("t4_next_data", 32'(data), 32'h5A);
      tick(1'b0, 1'b0, 1'b0);
      check_val("t4_fe_count", 32'(fe_seen - fe0), 32'h1);

      // 5: sof at bit 5 inside a frame that had overflowed
      for (int i = 0; i < 34; i++) send_word(WIDTH'(i + 7), 1'b0, i == 0);
      check_val("t5_ovf_before", 32'(ovf), 32'h1);
      dv0 = dv_seen;
      send_partial(8'hFF, 5, 1'b0);
      send_word(8'hC3, 1'b0, 1'b1);
      check_val("t5_ovf_cleared", 32'(ovf), 32'h0);
      check_val("t5_data", 32'(data), 32'hC3);
      tick(1'b0, 1'b0, 1'b0);
      check_val("t5_dv_count", 32'(dv_seen - dv0), 32'h1);

      // 6: async reset during the parity bit
      send_word(8'h81, 1'b0, 1'b1);
      send_partial(8'h7E, WIDTH, 1'b0);
      sin = 1'b0; sin_en = 1'b1; sof = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      check_val("t6_outs_zero",
                32'({data, data_valid, par_err, frame_err, busy, ovf}), 32'h0);
      tick(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick(1'($urandom), 1'b1, 1'b0);
      check_val("t6_ignored_busy", 32'(busy), 32'h0);
      check_val("t6_ignored_data", 32'(data), 32'h0);
      idle(2);

      // random frames
      for (int f = 0; f < 40; f++) begin
         nw = $urandom_range(1, 38);
         first = 1'b1;
         for (int k = 0; k < nw; k++) begin
            w = WIDTH'($urandom);
            r = $urandom_range(0, 19);
            if (r == 1) begin
               send_partial(w, $urandom_range(1, WIDTH), first);
               first = 1'b1;
            end else if (r == 2) begin
               send_partial(w, $urandom_range(1, WIDTH), first);
               break;
            end else begin
               send_word(w, r == 0, first);
               first = 1'b0;
            end
         end
         for (int i = 0; i < $urandom_range(1, 4); i++) tick(1'($urandom), 1'($urandom), 1'b0);
         tick(1'b0, 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
